vote_tally_ctrl: RTL and testbench
==================================

# vote_tally_ctrl

Central tally controller for the voting machine. It sits downstream of the per-candidate button conditioners, which each emit a one-cycle valid-vote pulse. It queues those pulses and arbitrates round-robin when several candidates vote at once. It commits exactly one vote per grant into saturating per-candidate counters, then enforces a lockout window before the next commit. In result mode it stops accepting votes and serves counts to the display.

## Interface
- `N_CAND`, 4: number of candidates (2..16).
- `CNT_W`, 8: width of each vote counter.
- `LOCK_CYCLES`, 16: lockout length in cycles after each commit (≥1).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `vote_valid` in N_CAND: one-cycle vote pulses, one bit per candidate.
- `mode` in 1: 0 = voting, 1 = result display.
- `sel` in $clog2(N_CAND): candidate index whose count is shown in result mode.
- `vote_ack` out 1: one-cycle pulse when a vote is committed.
- `ack_id` out $clog2(N_CAND): index of the last committed candidate.
- `busy` out 1: high in GRANT, COMMIT and LOCKOUT.
- `result` out CNT_W: registered count of candidate `sel`.

## Operation
- Pending register `pend[N_CAND]`:
  - While `mode`=0, `pend <= pend | vote_valid`.
  - The bit for the committed candidate is cleared in COMMIT; clear wins over a same-cycle set for that bit.
  - Repeated pulses for a candidate already pending merge into one pending vote and are not counted twice.
- While `mode`=1, `vote_valid` is ignored (not latched). Bits already in `pend` are retained.
- FSM states: IDLE, GRANT, COMMIT, LOCKOUT.
  - IDLE: if `mode`=0 and `pend`≠0, go to GRANT. Otherwise stay.
  - GRANT: the round-robin arbiter picks the first set `pend` bit at or after pointer `rr_ptr`, wrapping modulo N_CAND. The grant index is registered. Go to COMMIT.
  - COMMIT:
    - `cnt[g] <= cnt[g]+1`, saturating at 2^CNT_W−1.
    - Clear `pend[g]`.
    - Pulse `vote_ack`, set `ack_id=g`.
    - `rr_ptr <= (g+1) mod N_CAND`.
    - Load the lockout timer with LOCK_CYCLES−1. Go to LOCKOUT.
  - LOCKOUT: the timer decrements each cycle. When it is 0, go to IDLE. Votes arriving during LOCKOUT are still queued.
- A change of `mode` to 1 while in GRANT, COMMIT or LOCKOUT does not abort the sequence. The current vote commits and lockout completes. The FSM then stays in IDLE until `mode` returns to 0.
- `result <= cnt[sel]` every cycle, in both modes. If `sel` ≥ N_CAND, `result` is 0.
- A saturated counter still produces `vote_ack`; its value is unchanged.
- Reset values:
  - all `cnt`=0, `pend`=0, `rr_ptr`=0, timer=0, state IDLE;
  - `vote_ack`=0, `ack_id`=0, `busy`=0, `result`=0.
- Asserting `rst` mid-sequence discards any pending and in-flight vote immediately.

## Timing
- A `vote_valid` pulse in cycle t:
  - sets `pend` at edge t+1;
  - moves the FSM to GRANT at t+2 and COMMIT at t+3, with `vote_ack` high in cycle t+3;
  - makes `result` reflect the new count at t+4 when `sel`=g.
- Minimum spacing between consecutive `vote_ack` pulses: LOCK_CYCLES+3 cycles (COMMIT, LOCKOUT×LOCK_CYCLES, IDLE, GRANT).
- `busy` is registered and aligned with the state: high from the GRANT cycle through the last LOCKOUT cycle.
- `result` has one cycle of latency from `sel`.

## Configuration
- `VOTE_TOTAL_EN` defined:
  - adds output `total` [CNT_W+$clog2(N_CAND)-1:0], reset 0;
  - `total` increments on every COMMIT in which `cnt[g]` actually increased (not when saturated);
  - `total` is registered in the same edge as `cnt`.
- `VOTE_TOTAL_EN` undefined: no `total` port and no total logic.

## Structure
- Package `vote_pkg` holds:
  - the state enum `vote_state_t` (IDLE, GRANT, COMMIT, LOCKOUT);
  - default constants `VOTE_N_CAND`, `VOTE_CNT_W`, `VOTE_LOCK_CYCLES`.
- Sub-module `rr_arbiter`:
  - purely combinational, parameterised on N;
  - inputs `req[N]` and `ptr`; outputs `gnt_idx` and `gnt_valid`;
  - instantiated once.

## Test plan
- Reset, then single vote `vote_valid`=4'b0010 at t → `vote_ack` at t+3, `ack_id`=1; with `sel`=1, `result`=1 at t+4.
- Simultaneous `vote_valid`=4'b1011, `rr_ptr`=0 → acks in order 0, 1, 3, spaced LOCK_CYCLES+3 apart; final counts 1, 1, 0, 1.
- Candidate 2 pulsed 3 times within its pending window → exactly one ack and `cnt[2]`=1.
- CNT_W=2: candidate 0 voted 5 times → `cnt[0]`=3 and 5 acks; with `VOTE_TOTAL_EN`, `total`=3.
- `mode`=1 set during LOCKOUT, with a new pulse on candidate 3 → the in-flight commit completes, the candidate-3 pulse is ignored, and there is no further ack; `sel`=0..3 read back the counts.
- `rst` asserted during COMMIT → all outputs 0 asynchronously and counts cleared; after release, a single vote gives `result`=1.

Source files
------------

// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vote_pkg
//  Description : Shared types and default constants for the vote tally
//                controller. It holds the FSM state encoding and the default
//                parameter values used by vote_tally_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package vote_pkg;

  // Default configuration
  localparam int VOTE_N_CAND      = 4;
  localparam int VOTE_CNT_W       = 8;
  localparam int VOTE_LOCK_CYCLES = 16;

  // Tally FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    COMMIT  = 2'd2,
    LOCKOUT = 2'd3
  } vote_state_t;

endpackage
`default_nettype wire

// File: rtl/vote_tally_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. It grants the first set
//                request bit at or after the pointer, wrapping modulo N.
//  Ports       : req_i       - request vector, one bit per requester
//                ptr_i       - starting search position
//                gnt_idx_o   - index of the granted requester
//                gnt_valid_o - high when any request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  // The search runs from the farthest offset back toward the pointer, so the
  // last hit written is the one closest to the pointer, which is the winner.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % N]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = PTR_W'((int'(ptr_i) + off) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vote_tally_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vote_tally_ctrl
//  Description : Central vote tally controller. It queues one-cycle vote
//                pulses per candidate, grants them round-robin, commits one
//                vote per grant into saturating counters and then holds off
//                for a lockout window. In result mode, new votes are ignored
//                and the count of the selected candidate is shown.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                vote_valid_i  - one-cycle vote pulses, one per candidate
//                mode_i        - 0 = voting, 1 = result display
//                sel_i         - candidate whose count drives result_o
//                vote_ack_o    - one-cycle pulse on each committed vote
//                ack_id_o      - index of the last committed candidate
//                busy_o        - high in GRANT, COMMIT and LOCKOUT
//                total_o       - total of counted votes (VOTE_TOTAL_EN only)
//                result_o      - registered count of candidate sel_i
//  Config      : define VOTE_TOTAL_EN to add the total_o vote counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_tally_ctrl
  import vote_pkg::*;
#(
  parameter int N_CAND      = VOTE_N_CAND,
  parameter int CNT_W       = VOTE_CNT_W,
  parameter int LOCK_CYCLES = VOTE_LOCK_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CAND-1:0]                 vote_valid_i,
  input  logic                              mode_i,
  input  logic [$clog2(N_CAND)-1:0]         sel_i,
  output logic                              vote_ack_o,
  output logic [$clog2(N_CAND)-1:0]         ack_id_o,
  output logic                              busy_o,
`ifdef VOTE_TOTAL_EN
  output logic [CNT_W+$clog2(N_CAND)-1:0]   total_o,
`endif
  output logic [CNT_W-1:0]                  result_o
);

  localparam int              SEL_W   = $clog2(N_CAND);
  localparam int              TMR_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_ID  = SEL_W'(N_CAND - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  vote_state_t       state_q;
  logic [N_CAND-1:0] pend_q, pend_d;
  logic [SEL_W-1:0]  rr_ptr_q;
  logic [SEL_W-1:0]  gnt_q;
  logic [TMR_W-1:0]  timer_q;
  logic [CNT_W-1:0]  cnt_q [N_CAND];
  logic [CNT_W-1:0]  cnt_d [N_CAND];
  logic              cnt_inc;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              vote_ack_q;
  logic [SEL_W-1:0]  ack_id_q;
  logic              busy_q;

  logic [SEL_W-1:0]  arb_idx;
  logic              arb_valid;

  // --------------------------------------------------------------------------
  // Round-robin arbiter over the pending votes
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N     (N_CAND),
    .PTR_W (SEL_W)
  ) u_arb (
    .req_i       (pend_q),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // Pending votes: new pulses latch only in voting mode; the commit clear is
    // applied last so it wins over a same-cycle pulse for that candidate.
    pend_d = pend_q;
    if (!mode_i) begin
      pend_d = pend_d | vote_valid_i;
    end
    if (state_q == COMMIT) begin
      pend_d[gnt_q] = 1'b0;
    end

    cnt_d   = cnt_q;
    cnt_inc = 1'b0;
    if ((state_q == COMMIT) && (cnt_q[gnt_q] != CNT_MAX)) begin
      cnt_d[gnt_q] = cnt_q[gnt_q] + 1'b1;
      cnt_inc      = 1'b1;
    end

    // result_o is sampled from the next counter values, so a commit shows up
    // on the display in the cycle right after COMMIT.
    result_d = '0;
    if (int'(sel_i) < N_CAND) begin
      result_d = cnt_d[sel_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      result_q <= '0;
      for (int i = 0; i < N_CAND; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef VOTE_TOTAL_EN
  // --------------------------------------------------------------------------
  // Total of votes that actually changed a counter
  // --------------------------------------------------------------------------
  logic [CNT_W+SEL_W-1:0] total_q, total_d;

  always_comb begin
    total_d = total_q + (CNT_W + SEL_W)'(cnt_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_o = total_q;
`endif

  // --------------------------------------------------------------------------
  // Tally FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      timer_q    <= '0;
      vote_ack_q <= 1'b0;
      ack_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      vote_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!mode_i && (pend_q != '0)) begin
            state_q <= GRANT;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          // The ack is launched here so that it is high during COMMIT.
          if (arb_valid) begin
            state_q    <= COMMIT;
            gnt_q      <= arb_idx;
            vote_ack_q <= 1'b1;
            ack_id_q   <= arb_idx;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COMMIT: begin
          state_q  <= LOCKOUT;
          rr_ptr_q <= (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
          timer_q  <= TMR_LOAD;
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vote_ack_o = vote_ack_q;
  assign ack_id_o   = ack_id_q;
  assign busy_o     = busy_q;
  assign result_o   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_tally_ctrl
//  Description : Self-checking bench for vote_tally_ctrl. Expected acks
//                (candidate and cycle) are queued by the stimulus and checked
//                by an independent monitor; counts and status are checked
//                against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_tally_ctrl;

  localparam int N       = 4;
  localparam int CW      = 2;
  localparam int L       = 4;
  localparam int SW      = 2;
  localparam int SPACING = L + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  vote_valid;
  logic          mode;
  logic [SW-1:0] sel;
  logic          vote_ack;
  logic [SW-1:0] ack_id;
  logic          busy;
  logic [CW-1:0] result;
`ifdef VOTE_TOTAL_EN
  logic [CW+SW-1:0] total;
`endif

  vote_tally_ctrl #(
    .N_CAND      (N),
    .CNT_W       (CW),
    .LOCK_CYCLES (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vote_valid_i (vote_valid),
    .mode_i       (mode),
    .sel_i        (sel),
    .vote_ack_o   (vote_ack),
    .ack_id_o     (ack_id),
    .busy_o       (busy),
`ifdef VOTE_TOTAL_EN
    .total_o      (total),
`endif
    .result_o     (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int cyc;
  } ack_exp_t;

  ack_exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ack(input int id, input int c);
    ack_exp_t e;
    e.id  = id;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every ack the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    ack_exp_t e;
    if (!rst && vote_ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: actual ack id %0d at cycle %0d, required no ack", ack_id, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_id", 32'(ack_id), e.id);
        check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  int t0;
  int exp_cnt_a [N] = '{1, 1, 0, 1};
  int exp_cnt_b [N] = '{2, 1, 1, 1};

  initial begin
    rst        = 1'b1;
    vote_valid = '0;
    mode       = 1'b0;
    sel        = '0;
    do_reset();

    // ---- reset state ----
    check("rst_vote_ack", 32'(vote_ack), 0);
    check("rst_ack_id",   32'(ack_id),   0);
    check("rst_busy",     32'(busy),     0);
    check("rst_result",   32'(result),   0);

    // ---- single vote, candidate 1: latency ----
    sel = 2'd1;
    t0  = cyc;
    expect_ack(1, t0 + 3);
    vote_valid = 4'b0010;
    tick(1);
    vote_valid = '0;
    check("single_busy_t1", 32'(busy), 0);
    tick(1);
    check("single_busy_grant", 32'(busy), 1);
    tick(1);
    check("single_ack_t3", 32'(vote_ack), 1);
    tick(1);
    check("single_result_t4", 32'(result), 1);
    check("single_ack_low", 32'(vote_ack), 0);
    check("single_ack_id_hold", 32'(ack_id), 1);
    tick(SPACING + 2);
    check("single_busy_done", 32'(busy), 0);

    // ---- simultaneous votes 1011 from rr_ptr=0 ----
    do_reset();
    t0 = cyc;
    expect_ack(0, t0 + 3);
    expect_ack(1, t0 + 3 + SPACING);
    expect_ack(3, t0 + 3 + 2 * SPACING);
    vote_valid = 4'b1011;
    tick(1);
    vote_valid = '0;
    tick(3 + 2 * SPACING + L + 3);
    for (int i = 0; i < N; i++) begin
      sel = SW'(i);
      tick(1);
      check($sformatf("multi_cnt%0d", i), 32'(result), exp_cnt_a[i]);
    end
    check("multi_last_ack_id", 32'(ack_id), 3);
`ifdef VOTE_TOTAL_EN
    check("multi_total", 32'(total), 3);
`endif

    // ---- candidate 2 pulsed three times; last pulse lands in COMMIT ----
    t0 = cyc;
    expect_ack(2, t0 + 3);
    vote_valid = 4'b0100;
    tick(1);
    vote_valid = '0;
    tick(1);
    vote_valid = 4'b0100;
    tick(1);
    vote_valid = 4'b0100;
    tick(1);
    vote_valid = '0;
    tick(L + 8);
    check("merge_busy", 32'(busy), 0);
    sel = 2'd2;
    tick(1);
    check("merge_cnt2", 32'(result), 1);

    // ---- result mode entered during LOCKOUT with a new pulse ----
    t0 = cyc;
    expect_ack(0, t0 + 3);
    vote_valid = 4'b0001;
    tick(1);
    vote_valid = '0;
    tick(4);
    mode       = 1'b1;
    vote_valid = 4'b1000;
    tick(1);
    vote_valid = '0;
    check("mode_lockout_busy", 32'(busy), 1);
    tick(20);
    check("mode_idle_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) begin
      sel = SW'(i);
      tick(1);
      check($sformatf("mode_cnt%0d", i), 32'(result), exp_cnt_b[i]);
    end
    mode = 1'b0;
    tick(20);
    check("mode_back_busy", 32'(busy), 0);

    // ---- reset during COMMIT discards in-flight and pending votes ----
    t0 = cyc;
    expect_ack(2, t0 + 3);
    vote_valid = 4'b0101;
    tick(1);
    vote_valid = '0;
    tick(2);
    check("rstc_ack_before", 32'(vote_ack), 1);
    #2 rst = 1'b1;
    #1;
    check("rstc_vote_ack", 32'(vote_ack), 0);
    check("rstc_ack_id",   32'(ack_id),   0);
    check("rstc_busy",     32'(busy),     0);
    check("rstc_result",   32'(result),   0);
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    check("rstc_busy_after", 32'(busy), 0);
    for (int i = 0; i < N; i++) begin
      sel = SW'(i);
      tick(1);
      check($sformatf("rstc_cnt%0d", i), 32'(result), 0);
    end
    sel = 2'd1;
    t0  = cyc;
    expect_ack(1, t0 + 3);
    vote_valid = 4'b0010;
    tick(1);
    vote_valid = '0;
    tick(3);
    check("rstc_revote_result", 32'(result), 1);
    tick(L + 4);

    // ---- saturation: candidate 0 voted five times with CNT_W=2 ----
    sel = 2'd0;
    for (int k = 0; k < 5; k++) begin
      t0 = cyc;
      expect_ack(0, t0 + 3);
      vote_valid = 4'b0001;
      tick(1);
      vote_valid = '0;
      tick(SPACING + 1);
      check($sformatf("sat_cnt0_vote%0d", k + 1), 32'(result), (k < 3) ? k + 1 : 3);
    end
`ifdef VOTE_TOTAL_EN
    check("sat_total", 32'(total), 4);
`endif

    tick(5);
    check("acks_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
